// File: rtl/immediate_gen_pipe.sv
// immediate_gen_pipe: decodes the RISC-V I/S/B/U/J immediates from an
// instruction word and sign-extends them to XLEN. The result sits in one
// output register stage, backed by a skid register so upstream can keep
// streaming while downstream stalls.
// Optional macro IMM_ZICSR_EN: adds the CSR uimm (Z) format for SYSTEM
// opcodes with funct3[2] set.
module immediate_gen_pipe #(
    parameter int XLEN    = 32,
    parameter int OP32_EN = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     Instruction_bus_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] Immediate_o,
    output logic [2:0]      fmt_o
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_ZICSR_EN
    localparam logic [2:0] FMT_Z    = 3'd6;
`endif

    // OP-IMM-32 only exists on RV64
    localparam bit OP32_ACT = (XLEN == 64) && (OP32_EN != 0);

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [31:0]     dec_w;
    logic [2:0]      dec_fmt;
    logic [XLEN-1:0] dec_imm;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_imm_q,   out_imm_d;
    logic [2:0]      out_fmt_q,   out_fmt_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q,  skid_imm_d;
    logic [2:0]      skid_fmt_q,  skid_fmt_d;

    logic            accept;
    logic            xfer;

    assign instr  = Instruction_bus_i;
    assign opcode = instr[6:0];

    // Immediate decode into a 32-bit field; the Z field has bit 31 clear so
    // the common sign extension below zero-extends it.
    always_comb begin
        dec_w   = '0;
        dec_fmt = FMT_NONE;
        case (opcode)
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec_w   = {{20{instr[31]}}, instr[31:20]};
                dec_fmt = FMT_I;
            end
            7'b0011011: begin
                if (OP32_ACT) begin
                    dec_w   = {{20{instr[31]}}, instr[31:20]};
                    dec_fmt = FMT_I;
                end
            end
            7'b0100011: begin
                dec_w   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                dec_fmt = FMT_S;
            end
            7'b1100011: begin
                dec_w   = {{19{instr[31]}}, instr[31], instr[7],
                           instr[30:25], instr[11:8], 1'b0};
                dec_fmt = FMT_B;
            end
            7'b0110111, 7'b0010111: begin
                dec_w   = {instr[31:12], 12'b0};
                dec_fmt = FMT_U;
            end
            7'b1101111: begin
                dec_w   = {{11{instr[31]}}, instr[31], instr[19:12],
                           instr[20], instr[30:21], 1'b0};
                dec_fmt = FMT_J;
            end
`ifdef IMM_ZICSR_EN
            7'b1110011: begin
                if (instr[14]) begin
                    dec_w   = {27'b0, instr[19:15]};
                    dec_fmt = FMT_Z;
                end
            end
`endif
            default: begin
                dec_w   = '0;
                dec_fmt = FMT_NONE;
            end
        endcase
        dec_imm = {{(XLEN-31){dec_w[31]}}, dec_w[30:0]};
    end

    assign accept = in_valid_i & in_ready_o;
    assign xfer   = out_valid_q & out_ready_i;

    // Output stage / skid next-state: skid drains first, otherwise a new
    // entry lands in the output stage if it is free, else in the skid.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_fmt_d    = out_fmt_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        if (skid_valid_q) begin
            // in_ready_o is low here, so no accept can collide with the drain
            if (xfer) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_fmt_d    = skid_fmt_q;
                skid_valid_d = 1'b0;
            end
        end else if (!out_valid_q || xfer) begin
            out_valid_d = accept;
            if (accept) begin
                out_imm_d = dec_imm;
                out_fmt_d = dec_fmt;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_fmt_d   = dec_fmt;
        end
    end

    // State registers; reset flushes both entries at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_fmt_q    <= FMT_NONE;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= FMT_NONE;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_fmt_q    <= out_fmt_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
        end
    end

    // Ready comes straight from a flop: no path from out_ready_i
    assign in_ready_o  = !skid_valid_q;
    assign out_valid_o = out_valid_q;
    assign Immediate_o = out_imm_q;
    assign fmt_o       = out_fmt_q;

endmodule

// File: tb/tb_immediate_gen_pipe.sv
// Directed bench for immediate_gen_pipe: a 32-bit instance and a 64-bit
// instance with OP-IMM-32 enabled share one stimulus stream.
module tb_immediate_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] instr;
    logic        out_ready;

    logic        in_ready32, out_valid32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        in_ready64, out_valid64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    immediate_gen_pipe #(.XLEN(32), .OP32_EN(0)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid), .in_ready_o(in_ready32),
        .Instruction_bus_i(instr),
        .out_valid_o(out_valid32), .out_ready_i(out_ready),
        .Immediate_o(imm32), .fmt_o(fmt32)
    );

    immediate_gen_pipe #(.XLEN(64), .OP32_EN(1)) u_dut64 (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid), .in_ready_o(in_ready64),
        .Instruction_bus_i(instr),
        .out_valid_o(out_valid64), .out_ready_i(out_ready),
        .Immediate_o(imm64), .fmt_o(fmt64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One instruction through both instances with the output always ready
    task automatic send(input string tag, input logic [31:0] w,
                        input logic [31:0] e32, input logic [2:0] f32,
                        input logic [63:0] e64, input logic [2:0] f64);
        @(negedge clk);
        in_valid = 1'b1;
        instr    = w;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_v32"},   {63'b0, out_valid32}, 64'd1);
        chk({tag, "_imm32"}, {32'b0, imm32}, {32'b0, e32});
        chk({tag, "_fmt32"}, {61'b0, fmt32}, {61'b0, f32});
        chk({tag, "_imm64"}, imm64, e64);
        chk({tag, "_fmt64"}, {61'b0, fmt64}, {61'b0, f64});
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        instr     = 32'h0;
        out_ready = 1'b1;
        #12;
        chk("rst_valid", {63'b0, out_valid32}, 64'd0);
        chk("rst_ready", {63'b0, in_ready32}, 64'd1);
        chk("rst_imm",   {32'b0, imm32}, 64'd0);
        chk("rst_fmt",   {61'b0, fmt32}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single transfers, one per format
        send("addi",  32'hFFF00093, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFF_FFFFFFFF, 3'd1);
        send("sw",    32'hFE112E23, 32'hFFFFFFFC, 3'd2, 64'hFFFFFFFF_FFFFFFFC, 3'd2);
        send("beq",   32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 64'hFFFFFFFF_FFFFFFF8, 3'd3);
        send("lui",   32'h123452B7, 32'h12345000, 3'd4, 64'h00000000_12345000, 3'd4);
        send("rtype", 32'h00000033, 32'h00000000, 3'd0, 64'h0, 3'd0);
        send("jal",   32'h0080006F, 32'h00000008, 3'd5, 64'h8, 3'd5);
        send("lw",    32'h00402103, 32'h00000004, 3'd1, 64'h4, 3'd1);
        send("lui64", 32'h800000B7, 32'h80000000, 3'd4, 64'hFFFFFFFF_80000000, 3'd4);
        // addiw: I-type only on the RV64 instance
        send("addiw", 32'hFFF0009B, 32'h00000000, 3'd0, 64'hFFFFFFFF_FFFFFFFF, 3'd1);
`ifdef IMM_ZICSR_EN
        send("csrrwi", 32'h3401D073, 32'h00000003, 3'd6, 64'h3, 3'd6);
`else
        send("csrrwi", 32'h3401D073, 32'h00000000, 3'd0, 64'h0, 3'd0);
`endif
        @(negedge clk);
        chk("idle_valid", {63'b0, out_valid32}, 64'd0);

        // Stall: output blocked for three edges while addi, sw, beq are offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'hFFF00093;
        @(negedge clk);
        chk("st_ready1", {63'b0, in_ready32}, 64'd1);
        instr = 32'hFE112E23;
        @(negedge clk);
        chk("st_ready2", {63'b0, in_ready32}, 64'd0);
        chk("st_hold1",  {32'b0, imm32}, 64'hFFFFFFFF);
        instr = 32'hFE000CE3;
        @(negedge clk);
        chk("st_ready3", {63'b0, in_ready32}, 64'd0);
        chk("st_hold2",  {32'b0, imm32}, 64'hFFFFFFFF);
        chk("st_holdf",  {61'b0, fmt32}, 64'd1);
        chk("st_holdv",  {63'b0, out_valid32}, 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("dr_sw",    {32'b0, imm32}, 64'hFFFFFFFC);
        chk("dr_swf",   {61'b0, fmt32}, 64'd2);
        chk("dr_ready", {63'b0, in_ready32}, 64'd1);
        @(negedge clk);
        chk("dr_beq",  {32'b0, imm32}, 64'hFFFFFFF8);
        chk("dr_beqf", {61'b0, fmt32}, 64'd3);
        instr = 32'h123452B7;
        @(negedge clk);
        in_valid = 1'b0;
        chk("dr_lui",  {32'b0, imm32}, 64'h12345000);
        chk("dr_luif", {61'b0, fmt32}, 64'd4);
        @(negedge clk);
        chk("dr_empty", {63'b0, out_valid32}, 64'd0);

        // Reset with output stage and skid both full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'hFFF00093;
        @(negedge clk);
        instr = 32'hFE112E23;
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_ready", {63'b0, in_ready32}, 64'd0);
        reset = 1'b1;
        #1;
        chk("flush_valid", {63'b0, out_valid32}, 64'd0);
        chk("flush_ready", {63'b0, in_ready32}, 64'd1);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        send("post_jal", 32'h0080006F, 32'h00000008, 3'd5, 64'h8, 3'd5);
        @(negedge clk);
        chk("post_alone", {63'b0, out_valid32}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/immediate_gen_pipe.md
Name: immediate_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the RISC-V datapath.
- Decodes every RV32I/RV64I immediate format (I, S, B, U, J) from the instruction word and sign-extends to XLEN.
- Carries a valid/ready handshake with a 2-entry skid buffer, so decode/execute stages can stall without dropping instructions.
- Sits between instruction fetch/decode and the ALU operand mux; one register stage, full throughput.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- OP32_EN, 0, when 1 and XLEN=64, opcode 0011011 (OP-IMM-32) decodes as I-type; ignored when XLEN=32.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid_i  input  1  instruction word valid.
- in_ready_o  output  1  block can accept an instruction this cycle.
- Instruction_bus_i  input  32  instruction word.
- out_valid_o  output  1  Immediate_o / fmt_o valid.
- out_ready_i  input  1  downstream accepts the output this cycle.
- Immediate_o  output  XLEN  sign-extended immediate.
- fmt_o  output  3  format code: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR uimm).

Behaviour:
- Reset (async, active-high): out_valid_o=0, Immediate_o=0, fmt_o=0, skid entry invalid, in_ready_o=1.
- Decode is combinational on opcode = Instruction_bus_i[6:0]; the result is registered.
- I-type (0010011, 0000011, 1100111, and 0011011 per OP32_EN): sext(instr[31:20]).
- S-type (0100011): sext({instr[31:25], instr[11:7]}).
- B-type (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- U-type (0110111, 0010111): sext({instr[31:12], 12'b0}). For XLEN=64, bits 63:32 replicate instr[31].
- J-type (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- Any other opcode: Immediate_o=0, fmt_o=0. The entry is still passed through with valid.
- Handshake: an accept happens when in_valid_i & in_ready_o; an output transfer happens when out_valid_o & out_ready_i.
- in_ready_o = !skid_valid. It is registered, with no combinational path from out_ready_i.
- Latency: an accept in cycle N gives out_valid_o=1 with the result in cycle N+1, when the output stage is empty or transferring.
- Output stage empty or transferring, skid empty: the accepted entry loads the output stage.
- Output stage holding without transferring, new accept: the entry goes to the skid register and in_ready_o drops next cycle.
- Output transfers while skid is valid: the skid entry moves to the output stage and the skid clears. A simultaneous accept is impossible because in_ready_o=0.
- Output stage holds stable (value and fmt) while out_valid_o=1 & out_ready_i=0.
- Ordering is strictly FIFO. No entry is ever dropped or duplicated.
- Reset mid-operation flushes both the output stage and the skid entry immediately.

Optional Feature:
- Macro: IMM_ZICSR_EN.
- Defined: opcode 1110011 with instr[14]=1 produces a zero-extended 5-bit instr[19:15] (Z format) with fmt_o=6.
- Undefined: opcode 1110011 is treated as "other" (Immediate_o=0, fmt_o=0), and the Z-format logic is absent.

Test Plan:
- Reset, then addi 0xFFF00093 with out_ready_i=1 -> next cycle: out_valid_o=1, Immediate_o=0xFFFFFFFF, fmt_o=1.
- sw 0xFE112E23 -> 0xFFFFFFFC, fmt 2. beq 0xFE000CE3 -> 0xFFFFFFF8, fmt 3. lui 0x123452B7 -> 0x12345000, fmt 4. R-type 0x00000033 -> 0x00000000, fmt 0.
- Back-to-back addi, sw, beq, lui with out_ready_i=0 for 3 cycles:
  - First two are accepted, then in_ready_o=0.
  - Output holds 0xFFFFFFFF stable.
  - After release, outputs arrive in order with no loss.
- Assert reset while the output stage and skid are both full -> out_valid_o=0 and in_ready_o=1 immediately; the next accepted instruction emerges alone.
- XLEN=64: lui 0x800000B7 -> 0xFFFFFFFF80000000. With OP32_EN=1, addiw 0xFFF0009B -> all ones, fmt 1.
- IMM_ZICSR_EN defined: csrrwi 0x3401D073 -> 0x00000003, fmt 6. Undefined -> 0, fmt 0.
